s2mm_burst_writer: RTL
======================

Name: s2mm_burst_writer

Overview:
AXI4 write master that moves a free-running AXI-Stream sample feed into the DDR ring buffers owned by the buffer sync manager. Samples are collected in a small FIFO and written as fixed-length INCR bursts to the buffer base address supplied by the manager. The block emits one `writing` strobe per completed W beat, which lets the manager rotate its buffers. It sits between the ADC/filter stream and the HP port interconnect.

Parameters:
MM_ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, stream and AXI data width; power of two, 32..128.
LOG_BURST, 4, log2 of beats per burst (16 beats); range 0..8.
LOG_FIFO_DEPTH, 5, log2 of FIFO entries (32); must be greater than LOG_BURST.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
enable  in  1  capture enable
log_length  in  5  log2 of beats per buffer
buffer_address  in  MM_ADDR_WIDTH  byte base of the current write buffer, from sync manager
writing  out  1  one-cycle strobe per W handshake
overflow  out  1  sticky: sample dropped because the FIFO was full
error  out  1  sticky: BRESP != OKAY
s_axis_tdata  in  DATA_WIDTH  sample
s_axis_tvalid  in  1  sample valid (no tready; the source cannot stall)
m_axi_awaddr  out  MM_ADDR_WIDTH  burst address
m_axi_awlen  out  8  constant 2^LOG_BURST-1
m_axi_awsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid / m_axi_awready  out/in  1  address handshake
m_axi_wdata  out  DATA_WIDTH  FIFO head
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid / m_axi_wready  out/in  1  data handshake
m_axi_bresp  in  2  write response
m_axi_bvalid / m_axi_bready  in/out  1  response handshake

Behaviour:
- Reset: state IDLE; FIFO empty; beat_offset=0. awvalid, wvalid, wlast, bready, writing, overflow and error are all 0. awaddr is 0.
- FIFO write: `enable & s_axis_tvalid & !full` pushes tdata.
  - `enable & tvalid & full` drops the sample and sets overflow. overflow stays set until reset.
  - While enable=0, samples are ignored.
- State IDLE:
  - If enable=0: flush the FIFO and clear beat_offset.
  - Else if fifo_count >= 2^LOG_BURST: go to ADDR next cycle. On that same edge, latch awaddr = buffer_address + (beat_offset << log2(DATA_WIDTH/8)).
- State ADDR: awvalid=1, held stable until awready. The cycle after the AW handshake, go to DATA.
- State DATA:
  - wvalid=1 with wdata = FIFO head. The FIFO pops on each W handshake.
  - A beat counter counts 0..2^LOG_BURST-1. wlast=1 when the counter is at max.
  - writing=1 in the same cycle as each W handshake (registered combinational of wvalid&wready is acceptable; it must coincide with the handshake cycle).
  - After the wlast handshake, go to RESP.
  - wvalid never drops mid-burst: DATA is entered only with a full burst in the FIFO.
- State RESP: bready=1. On bvalid, set error if bresp != 2'b00, then go to IDLE.
- beat_offset update: on entry to RESP, beat_offset += 2^LOG_BURST. If the result is >= 2^eff_log_length, it becomes 0 (wrap).
  - eff_log_length = max(log_length, LOG_BURST), sampled at the IDLE->ADDR edge.
  - Because of this clamp, a burst never crosses a buffer boundary.
- Width rules:
  - Address arithmetic is modulo 2^MM_ADDR_WIDTH.
  - beat_offset is MM_ADDR_WIDTH bits.
  - fifo_count has LOG_FIFO_DEPTH+1 bits.
- enable dropping mid-burst: the current burst completes through RESP, then IDLE flushes. No partial bursts are ever issued.
- Simultaneous push and pop: fifo_count is unchanged.
  - The full flag uses the pre-pop count, so a push when count==depth with a same-cycle pop is still dropped.
  - Implementer may relax this, but the verifier checks the stated rule.
- Reset mid-burst: everything returns to reset values on the next edge. The interconnect shares aresetn, so no AXI completion is required.
- Back-to-back bursts: IDLE costs one cycle. Minimum burst period is 2^LOG_BURST + 3 cycles, given zero-wait AXI.

Decomposition:
- Package s2mm_pkg: state enum (IDLE, ADDR, DATA, RESP), AXI_BURST_INCR, AXI_RESP_OKAY, function clog2 for awsize.
- One sub-module sync_fifo (DATA_WIDTH, LOG_DEPTH):
  - single clock, registered head, count output, push/pop, flush input.
  - Reusable by the ram reader.

Test Plan:
1. enable=1, log_length=5, buffer_address=0x1000_0000, 32 samples 0..31, AXI always ready.
   -> two bursts: awaddr 0x1000_0000 then 0x1000_0040, awlen=15; wdata 0..31 in order; wlast on beats 15 and 31; 32 writing pulses.
2. log_length=4, continuous samples for 3 bursts.
   -> beat_offset wraps every burst, so every awaddr = buffer_address.
   -> when buffer_address changes to 0x1000_0040 before the third burst, the third awaddr = 0x1000_0040.
3. wready toggling 1-0-1-0 mid-burst.
   -> wdata/wlast held during stalls; writing pulses only on handshake cycles; 16 total.
4. awready held 0 for 40 cycles while samples stream.
   -> FIFO fills at 32, the 33rd sample is dropped, overflow=1 and stays 1.
5. bresp=2'b10 on the second burst.
   -> error=1 sticky; the third burst still issues normally.
6. enable deasserted at beat 7 of a burst with 20 samples buffered.
   -> burst finishes 16 beats; the remaining 4 samples are flushed; no new AW; the next enable starts at offset 0.

Source files
------------

// File: rtl/s2mm_pkg.sv
// s2mm_pkg: shared FSM states, AXI constants and sizing helper for the stream-to-memory writer
package s2mm_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, flush, and head read straight from storage
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [LOG_DEPTH:0]    o_count,
  output logic                  o_full
);
  logic [DATA_WIDTH-1:0] r_mem [2**LOG_DEPTH];
  logic [LOG_DEPTH-1:0] r_wptr, r_rptr;
  logic [LOG_DEPTH:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count[LOG_DEPTH];
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & (r_count != '0);
  assign o_head = r_mem[r_rptr];
  assign o_count = r_count;
  // pointers and occupancy; full is judged on the pre-pop count
  always_ff @(posedge aclk)
    if (!aresetn || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (LOG_DEPTH+1)'(w_push) - (LOG_DEPTH+1)'(w_pop);
    end
  // sample storage carries no reset
  always_ff @(posedge aclk)
    if (w_push) r_mem[r_wptr] <= i_din;
endmodule

// File: rtl/s2mm_burst_writer.sv
// s2mm_burst_writer: buffers an unstallable sample stream and writes it to DDR as fixed INCR bursts
module s2mm_burst_writer
  import s2mm_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOG_BURST = 4,
  parameter int LOG_FIFO_DEPTH = 5
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic [4:0]                log_length,
  input  logic [MM_ADDR_WIDTH-1:0]  buffer_address,
  output logic                      writing,
  output logic                      overflow,
  output logic                      error,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic [MM_ADDR_WIDTH-1:0]  m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready
);
  localparam int BEATS = 2**LOG_BURST;
  localparam int SIZE = clog2(DATA_WIDTH/8);
  state_t r_state, w_next;
  logic [MM_ADDR_WIDTH-1:0] r_beat_offset, r_awaddr;
  logic [4:0] r_eff_log, w_eff_log;
  logic [LOG_BURST:0] r_beat;
  logic r_overflow, r_error;
  logic [LOG_FIFO_DEPTH:0] w_count;
  logic [DATA_WIDTH-1:0] w_head;
  logic [MM_ADDR_WIDTH:0] w_off_next;
  logic w_full, w_whs, w_last, w_flush, w_launch;
  assign w_eff_log = (log_length < 5'(LOG_BURST)) ? 5'(LOG_BURST) : log_length;
  assign w_whs = m_axi_wvalid & m_axi_wready;
  assign w_last = r_beat == (LOG_BURST+1)'(BEATS-1);
  assign w_off_next = {1'b0, r_beat_offset} + (MM_ADDR_WIDTH+1)'(BEATS);
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .LOG_DEPTH(LOG_FIFO_DEPTH)) u_fifo (
    .aclk(aclk), .aresetn(aresetn), .i_push(enable & s_axis_tvalid), .i_pop(w_whs),
    .i_flush(w_flush), .i_din(s_axis_tdata), .o_head(w_head), .o_count(w_count), .o_full(w_full)
  );
  // state register
  always_ff @(posedge aclk)
    if (!aresetn) r_state <= IDLE;
    else r_state <= w_next;
  // next state and handshake outputs; a burst starts only once a whole burst is buffered
  always_comb begin
    w_next = r_state;
    w_flush = 1'b0;
    w_launch = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    case (r_state)
      IDLE: begin
        w_flush = ~enable;
        w_launch = enable && (w_count >= (LOG_FIFO_DEPTH+1)'(BEATS));
        w_next = w_launch ? ADDR : IDLE;
      end
      ADDR: begin
        m_axi_awvalid = 1'b1;
        w_next = m_axi_awready ? DATA : ADDR;
      end
      DATA: begin
        m_axi_wvalid = 1'b1;
        w_next = (m_axi_wready && w_last) ? RESP : DATA;
      end
      default: begin
        m_axi_bready = 1'b1;
        w_next = m_axi_bvalid ? IDLE : RESP;
      end
    endcase
  end
  // address, buffer offset, beat counter and sticky status flags
  always_ff @(posedge aclk)
    if (!aresetn) begin
      r_beat_offset <= '0;
      r_awaddr <= '0;
      r_eff_log <= '0;
      r_beat <= '0;
      r_overflow <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (enable && s_axis_tvalid && w_full) r_overflow <= 1'b1;
      if (w_flush) r_beat_offset <= '0;
      if (w_launch) begin
        r_awaddr <= buffer_address + (r_beat_offset << SIZE);
        r_eff_log <= w_eff_log;
      end
      if (w_whs) r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (w_whs && w_last)
        r_beat_offset <= (w_off_next >= ((MM_ADDR_WIDTH+1)'(1) << r_eff_log)) ? '0 : w_off_next[MM_ADDR_WIDTH-1:0];
      if (m_axi_bvalid && m_axi_bready && m_axi_bresp != AXI_RESP_OKAY) r_error <= 1'b1;
    end
  assign m_axi_awaddr = r_awaddr;
  assign m_axi_awlen = 8'(BEATS-1);
  assign m_axi_awsize = 3'(SIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata = w_head;
  assign m_axi_wstrb = '1;
  assign m_axi_wlast = m_axi_wvalid & w_last;
  assign writing = w_whs;
  assign overflow = r_overflow;
  assign error = r_error;
endmodule
